// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/LAP/PAUSE state machine, centisecond BCD
// counter mm:ss.cc with lap latch, and a free-running debounce enable.
module stopwatch_ctrl #(
  parameter int CS_DIV  = 500000,
  parameter int DEB_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        lap_reset,
  output logic        deb_en,
  output logic [1:0]  state,
  output logic [23:0] disp_bcd,
  output logic        wrap
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_LAP   = 2'b10,
    ST_PAUSE = 2'b11
  } state_t;

  localparam int CS_W  = (CS_DIV  > 2) ? $clog2(CS_DIV)  : 1;
  localparam int DEB_W = (DEB_DIV > 2) ? $clog2(DEB_DIV) : 1;
  localparam logic [CS_W-1:0]  CS_LAST  = CS_W'(CS_DIV - 1);
  localparam logic [CS_W-1:0]  CS_ONE   = CS_W'(1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
  localparam logic [23:0]      CNT_MAX  = 24'h595999;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CS_W-1:0]   cs_cnt_r;
  logic [DEB_W-1:0]  deb_cnt_r;
  logic [23:0]       count_r;
  logic [23:0]       lap_r;
  logic              deb_en_r;
  logic              wrap_r;
  logic              lap_load_s;
  logic              clear_cnt_s;
  logic              advancing_s;
  logic              cs_tick_s;

  // Ripple a +1 through six BCD digits; tens of seconds and minutes stop at 5.
  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    logic        carry;
    logic [3:0]  limit;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      limit = ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
      if (carry) begin
        if (r[i*4 +: 4] == limit) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Next-state logic; start_stop has priority over lap_reset.
  always_comb begin
    state_nxt_s = state_r;
    lap_load_s  = 1'b0;
    clear_cnt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_stop) state_nxt_s = ST_RUN;
        else            state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (start_stop) begin
          state_nxt_s = ST_PAUSE;
        end else if (lap_reset) begin
          state_nxt_s = ST_LAP;
          lap_load_s  = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_LAP: begin
        if (start_stop)     state_nxt_s = ST_PAUSE;
        else if (lap_reset) state_nxt_s = ST_RUN;
        else                state_nxt_s = ST_LAP;
      end
      ST_PAUSE: begin
        if (start_stop) begin
          state_nxt_s = ST_RUN;
        end else if (lap_reset) begin
          state_nxt_s = ST_IDLE;
          clear_cnt_s = 1'b1;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Prescaler advance qualifier and centisecond tick.
  always_comb begin
    advancing_s = (state_r == ST_RUN) || (state_r == ST_LAP);
    cs_tick_s   = advancing_s && (cs_cnt_r == CS_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Debounce enable divider, free-running in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt_r <= {DEB_W{1'b0}};
      deb_en_r  <= 1'b0;
    end else if (deb_cnt_r == DEB_LAST) begin
      deb_cnt_r <= {DEB_W{1'b0}};
      deb_en_r  <= 1'b1;
    end else begin
      deb_cnt_r <= deb_cnt_r + DEB_ONE;
      deb_en_r  <= 1'b0;
    end
  end

  // Centisecond prescaler: cleared in IDLE, frozen in PAUSE.
  always_ff @(posedge clk) begin
    if (reset || (state_r == ST_IDLE) || cs_tick_s) cs_cnt_r <= {CS_W{1'b0}};
    else if (advancing_s)                           cs_cnt_r <= cs_cnt_r + CS_ONE;
    else                                            cs_cnt_r <= cs_cnt_r;
  end

  // Count, lap latch and roll-over pulse; lap captures the pre-tick value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 24'h000000;
      lap_r   <= 24'h000000;
      wrap_r  <= 1'b0;
    end else begin
      if (clear_cnt_s)    count_r <= 24'h000000;
      else if (cs_tick_s) count_r <= bcd_inc(count_r);
      else                count_r <= count_r;
      if (lap_load_s) lap_r <= count_r;
      else            lap_r <= lap_r;
      wrap_r <= cs_tick_s && (count_r == CNT_MAX);
    end
  end

  // Display source select.
  always_comb begin
    if (state_r == ST_LAP) disp_bcd = lap_r;
    else                   disp_bcd = count_r;
  end

  assign state  = state_r;
  assign deb_en = deb_en_r;
  assign wrap   = wrap_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with CS_DIV=4, DEB_DIV=3.
module tb_stopwatch_ctrl;
  logic        clk;
  logic        reset;
  logic        start_stop;
  logic        lap_reset;
  logic        deb_en;
  logic [1:0]  state;
  logic [23:0] disp_bcd;
  logic        wrap;
  int checks;
  int errors;

  stopwatch_ctrl #(.CS_DIV(4), .DEB_DIV(3)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap_reset(lap_reset),
    .deb_en(deb_en), .state(state), .disp_bcd(disp_bcd), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic exp_deb;
    reset = 1'b1; start_stop = 1'b0; lap_reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_state got %b exp 00", state); end
    checks++; if (disp_bcd !== 24'h000000) begin errors++; $display("FAIL rst_disp got %h exp 000000", disp_bcd); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL rst_wrap got %b exp 0", wrap); end
    checks++; if (deb_en !== 1'b0) begin errors++; $display("FAIL rst_deb got %b exp 0", deb_en); end
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      exp_deb = ((k % 3) == 0);
      checks++; if (deb_en !== exp_deb) begin errors++; $display("FAIL deb_cycle%0d got %b exp %b", k, deb_en, exp_deb); end
    end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL idle_state got %b exp 00", state); end
    checks++; if (disp_bcd !== 24'h000000) begin errors++; $display("FAIL idle_disp got %h exp 000000", disp_bcd); end
  endtask

  task automatic test_run_pause();
    start_stop = 1'b1; @(negedge clk); start_stop = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL run_state got %b exp 01", state); end
    checks++; if (disp_bcd !== 24'h000010) begin errors++; $display("FAIL run_disp got %h exp 000010", disp_bcd); end
    start_stop = 1'b1; @(negedge clk); start_stop = 1'b0;
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL pause_state got %b exp 11", state); end
    repeat (10) @(negedge clk);
    checks++; if (disp_bcd !== 24'h000010) begin errors++; $display("FAIL pause_frozen got %h exp 000010", disp_bcd); end
  endtask

  task automatic test_clear();
    lap_reset = 1'b1; @(negedge clk); lap_reset = 1'b0;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL clr_state got %b exp 00", state); end
    checks++; if (disp_bcd !== 24'h000000) begin errors++; $display("FAIL clr_disp got %h exp 000000", disp_bcd); end
    lap_reset = 1'b1; @(negedge clk); lap_reset = 1'b0;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL idle_lr_state got %b exp 00", state); end
    checks++; if (disp_bcd !== 24'h000000) begin errors++; $display("FAIL idle_lr_disp got %h exp 000000", disp_bcd); end
  endtask

  task automatic test_lap();
    start_stop = 1'b1; @(negedge clk); start_stop = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (disp_bcd !== 24'h000005) begin errors++; $display("FAIL lap_pre got %h exp 000005", disp_bcd); end
    lap_reset = 1'b1; @(negedge clk); lap_reset = 1'b0;
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL lap_state got %b exp 10", state); end
    repeat (12) @(negedge clk);
    checks++; if (disp_bcd !== 24'h000005) begin errors++; $display("FAIL lap_hold got %h exp 000005", disp_bcd); end
    lap_reset = 1'b1; @(negedge clk); lap_reset = 1'b0;
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL lap_back_state got %b exp 01", state); end
    checks++; if (disp_bcd !== 24'h000008) begin errors++; $display("FAIL lap_live got %h exp 000008", disp_bcd); end
    // lap pulse lands on the tick edge: latch must hold the pre-tick count
    @(negedge clk);
    lap_reset = 1'b1; @(negedge clk); lap_reset = 1'b0;
    checks++; if (disp_bcd !== 24'h000008) begin errors++; $display("FAIL lap_pretick got %h exp 000008", disp_bcd); end
    lap_reset = 1'b1; @(negedge clk); lap_reset = 1'b0;
    checks++; if (disp_bcd !== 24'h000009) begin errors++; $display("FAIL lap_after got %h exp 000009", disp_bcd); end
    repeat (2) @(negedge clk);
    start_stop = 1'b1; @(negedge clk); start_stop = 1'b0;
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL tick_pause_state got %b exp 11", state); end
    checks++; if (disp_bcd !== 24'h000010) begin errors++; $display("FAIL tick_pause_disp got %h exp 000010", disp_bcd); end
  endtask

  task automatic test_simultaneous();
    start_stop = 1'b1; @(negedge clk); start_stop = 1'b0;
    repeat (6) @(negedge clk);
    start_stop = 1'b1; lap_reset = 1'b1; @(negedge clk); start_stop = 1'b0; lap_reset = 1'b0;
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL both_state got %b exp 11", state); end
    checks++; if (disp_bcd !== 24'h000011) begin errors++; $display("FAIL both_disp got %h exp 000011", disp_bcd); end
  endtask

  task automatic test_wrap();
    lap_reset = 1'b1; @(negedge clk); lap_reset = 1'b0;
    start_stop = 1'b1; @(negedge clk); start_stop = 1'b0;
    force dut.count_r = 24'h595999;
    @(negedge clk);
    release dut.count_r;
    checks++; if (disp_bcd !== 24'h595999) begin errors++; $display("FAIL wrap_load got %h exp 595999", disp_bcd); end
    repeat (2) @(negedge clk);
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_early got %b exp 0", wrap); end
    @(negedge clk);
    checks++; if (disp_bcd !== 24'h000000) begin errors++; $display("FAIL wrap_disp got %h exp 000000", disp_bcd); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wrap_pulse got %b exp 1", wrap); end
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL wrap_state got %b exp 01", state); end
    @(negedge clk);
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_width got %b exp 0", wrap); end
    force dut.count_r = 24'h000999;
    @(negedge clk);
    release dut.count_r;
    repeat (2) @(negedge clk);
    checks++; if (disp_bcd !== 24'h001000) begin errors++; $display("FAIL carry_disp got %h exp 001000", disp_bcd); end
  endtask

  task automatic test_reset_in_lap();
    lap_reset = 1'b1; @(negedge clk); lap_reset = 1'b0;
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL lap2_state got %b exp 10", state); end
    checks++; if (disp_bcd !== 24'h001000) begin errors++; $display("FAIL lap2_disp got %h exp 001000", disp_bcd); end
    reset = 1'b1; start_stop = 1'b1; lap_reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; start_stop = 1'b0; lap_reset = 1'b0;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL rlap_state got %b exp 00", state); end
    checks++; if (disp_bcd !== 24'h000000) begin errors++; $display("FAIL rlap_disp got %h exp 000000", disp_bcd); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL rlap_wrap got %b exp 0", wrap); end
    checks++; if (deb_en !== 1'b0) begin errors++; $display("FAIL rlap_deb got %b exp 0", deb_en); end
    repeat (2) @(negedge clk);
    checks++; if (deb_en !== 1'b0) begin errors++; $display("FAIL rlap_deb2 got %b exp 0", deb_en); end
    @(negedge clk);
    checks++; if (deb_en !== 1'b1) begin errors++; $display("FAIL rlap_deb3 got %b exp 1", deb_en); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_run_pause();
    test_clear();
    test_lap();
    test_simultaneous();
    test_wrap();
    test_reset_in_lap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
